// File: rtl/alu_result_stage_pkg.sv
// Shared constants for the ALU result / writeback stage.
// Branch codes, flag bit positions and buffered entry width.
package alu_result_stage_pkg;

  localparam int ARS_DATA_W = 16;
  localparam int ARS_REG_AW = 3;
  localparam int ENT_W      = ARS_DATA_W + ARS_REG_AW + 1;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_EQZ  = 3'b001;
  localparam logic [2:0] BR_NEZ  = 3'b010;
  localparam logic [2:0] BR_LTZ  = 3'b011;
  localparam logic [2:0] BR_GEZ  = 3'b100;
  localparam logic [2:0] BR_ALW  = 3'b101;
  localparam logic [2:0] BR_FZ   = 3'b110;

  localparam int FLG_Z   = 3;
  localparam int FLG_GZ  = 2;
  localparam int FLG_LZ  = 1;
  localparam int FLG_NEZ = 0;

  localparam logic [3:0] FLAGS_RST = 4'b1000;

endpackage

// File: rtl/alu_result_stage_skid_buffer2.sv
// Generic 2-entry FIFO skid buffer with valid/ready on both sides.
// in_ready is registered so out_ready never reaches it combinationally.
module skid_buffer2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] r_d0;
  logic [W-1:0] r_d1;
  logic [1:0]   r_count;
  logic         r_rdy;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_count_nx;

  assign in_ready  = r_rdy;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = out_valid ? r_d0 : '0;
  assign w_push    = in_valid && r_rdy;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    w_count_nx = r_count;
    if (w_push && !w_pop)
      w_count_nx = r_count + 2'd1;
    else if (w_pop && !w_push)
      w_count_nx = r_count - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d0    <= '0;
      r_d1    <= '0;
      r_count <= 2'd0;
      r_rdy   <= 1'b1;
    end else begin
      r_count <= w_count_nx;
      r_rdy   <= (w_count_nx != 2'd2);
      if (w_pop && r_count == 2'd2)
        r_d0 <= r_d1;
      if (w_push) begin
        if (r_count == 2'd0 || (r_count == 2'd1 && w_pop))
          r_d0 <= in_data;
        else
          r_d1 <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: buffered ALU result, flags, branch redirect.
// Optional overflow trap enabled by defining OFL_TRAP_EN.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int                DATA_W   = ARS_DATA_W,
  parameter int                REG_AW   = ARS_REG_AW,
  parameter logic [DATA_W-1:0] TRAP_VEC = 16'h0002
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_ofl,
  input  logic [3:0]        alu_flags,
  input  logic              chk_ofl,
  input  logic              flag_upd,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_reg,
  input  logic [2:0]        br_cond,
  input  logic [DATA_W-1:0] br_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_reg,
  output logic              wb_en,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [3:0]        flags,
  output logic              ofl_err
);

  localparam int EW = DATA_W + REG_AW + 1;

  logic [3:0]        r_flags;
  logic              r_redirect;
  logic [DATA_W-1:0] r_redirect_pc;
  logic              w_acc;
  logic              w_taken;
  logic              w_trap;
  logic              w_wen;
  logic [EW-1:0]     w_entry;
  logic [EW-1:0]     w_head;

  assign w_acc = in_valid && in_ready;

`ifdef OFL_TRAP_EN
  logic r_ofl_err;
  assign w_trap  = chk_ofl && alu_ofl;
  assign ofl_err = r_ofl_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ofl_err <= 1'b0;
    else if (w_acc && w_trap)
      r_ofl_err <= 1'b1;
  end
`else
  logic w_unused_ofl;
  assign w_unused_ofl = ^{chk_ofl, alu_ofl, TRAP_VEC};
  assign w_trap       = 1'b0;
  assign ofl_err      = 1'b0;
`endif

  // trapped entries must not write the register file
  assign w_wen   = wr_en && !w_trap;
  assign w_entry = {w_wen, wr_reg, alu_out};

  always_comb begin
    w_taken = 1'b0;
    unique case (br_cond)
      BR_EQZ:  w_taken = alu_flags[FLG_Z];
      BR_NEZ:  w_taken = alu_flags[FLG_NEZ];
      BR_LTZ:  w_taken = alu_flags[FLG_LZ];
      BR_GEZ:  w_taken = alu_flags[FLG_GZ] | alu_flags[FLG_Z];
      BR_ALW:  w_taken = 1'b1;
      BR_FZ:   w_taken = r_flags[FLG_Z];
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags       <= FLAGS_RST;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_redirect <= 1'b0;
      if (w_acc && flag_upd)
        r_flags <= alu_flags;
      if (w_acc && (w_taken || w_trap)) begin
        r_redirect    <= 1'b1;
        r_redirect_pc <= w_trap ? TRAP_VEC : br_target;
      end
    end
  end

  skid_buffer2 #(.W(EW)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_head)
  );

  assign wb_data     = w_head[DATA_W-1:0];
  assign wb_reg      = w_head[DATA_W +: REG_AW];
  assign wb_en       = w_head[EW-1];
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign flags       = r_flags;

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-to-writeback stage placed directly downstream of alu_unpipelined in the 16-bit processor.
- Registers the ALU result and flags (zf/gzf/lzf/nezf/Ofl) through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Resolves branch conditions from the same-cycle ALU flags or the stored flag register, and issues a one-cycle redirect to fetch.
- Presents writeback data, destination register and write enable to the register file.

Parameters:
- DATA_W, 16, datapath width (ALU Out, PC, targets)
- REG_AW, 3, register-file address width
- TRAP_VEC, 16'h0002, redirect PC for an overflow trap (used only with OFL_TRAP_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- alu_out  in  DATA_W  ALU Out
- alu_ofl  in  1  ALU Ofl
- alu_flags  in  4  {zf,gzf,lzf,nezf} from the ALU
- chk_ofl  in  1  instruction is signed; overflow is meaningful
- flag_upd  in  1  load flag register from alu_flags
- wr_en  in  1  instruction writes a register
- wr_reg  in  REG_AW  destination register
- br_cond  in  3  branch condition code
- br_target  in  DATA_W  branch target PC
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- wb_data  out  DATA_W  head result
- wb_reg  out  REG_AW  head destination
- wb_en  out  1  head write enable, qualified by out_valid
- redirect  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  DATA_W  redirect target, held until the next redirect
- flags  out  4  flag register {zf,gzf,lzf,nezf}
- ofl_err  out  1  sticky overflow error

Behaviour:
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- Buffer: 2 entries, FIFO order. count is 0..2. in_ready = (count != 2), registered with no combinational path from out_ready. out_valid = (count != 0).
- Latency: an entry accepted at edge N is visible at the outputs after edge N.
- Simultaneous push and pop with count=1: count stays 1; the new entry becomes head after the old head pops. With count=0, a push and no pop leaves count=1. Pop with count=0 is ignored.
- Outputs with count=0: wb_data, wb_reg and wb_en are 0.
- br_cond encoding (evaluated on accept):
  - 000: none
  - 001: taken if zf
  - 010: taken if nezf
  - 011: taken if lzf
  - 100: taken if gzf|zf
  - 101: always taken
  - 110: taken if the stored flags zf bit is set, using its value before this entry's flag_upd
  - 111: none
- A taken branch at acceptance edge N sets redirect=1 for exactly the cycle after N and loads redirect_pc = br_target. Redirect is independent of downstream backpressure.
- Flag register: loads alu_flags on accept when flag_upd=1; otherwise holds.
- Reset (async, any time, including mid-transfer): count=0, all buffered entries discarded, in_ready=1 after release, out_valid=0, wb_* = 0, redirect=0, redirect_pc=0, flags=4'b1000 (zero state), ofl_err=0.

Optional Feature:
- Macro: OFL_TRAP_EN
- Defined: an accept with chk_ofl && alu_ofl has the following effects.
  - The entry is stored with wr_en forced to 0.
  - ofl_err is set and stays 1 until reset.
  - redirect pulses with redirect_pc = TRAP_VEC. The trap overrides any branch on the same entry.
- Undefined: alu_ofl and chk_ofl are ignored, and ofl_err is tied to 0.

Decomposition:
- Shared package holds:
  - br_cond localparams (BR_NONE, BR_EQZ, BR_NEZ, BR_LTZ, BR_GEZ, BR_ALW, BR_FZ)
  - flag bit indices FLG_Z, FLG_GZ, FLG_LZ, FLG_NEZ
  - entry width constant (DATA_W + REG_AW + 1)
- Sub-module skid_buffer2 (generic 2-entry valid/ready buffer with a width parameter). Branch resolution and the flag register stay in the top module.

Test Plan:
- Reset, then accept alu_out=16'h0005, alu_flags=4'b0101, wr_en=1, wr_reg=3, out_ready=1 -> next cycle out_valid=1, wb_data=16'h0005, wb_reg=3, wb_en=1, redirect=0.
- Accept alu_out=16'hFFFB, alu_flags=4'b0011, br_cond=011, br_target=16'h0040 -> redirect=1 for exactly one cycle, redirect_pc=16'h0040.
- With out_ready=0, offer 16'h1400, 16'hAA00, 16'hBD8A back-to-back -> in_ready drops after two accepts and the third is held. Raise out_ready -> outputs drain in order 1400, AA00, BD8A with no loss or duplication.
- Accept flag_upd=1 with alu_flags=4'b1000, then br_cond=110 with alu_flags=4'b0101 -> taken using the stored zf.
- Fill the buffer to 2 entries, pulse rst_n low mid-cycle -> out_valid=0 and flags=4'b1000 immediately, in_ready=1 after release.
- OFL_TRAP_EN defined: accept chk_ofl=1, alu_ofl=1, wr_en=1 -> wb_en=0, ofl_err=1 and sticky, redirect_pc=16'h0002. Without the macro, the same stimulus gives wb_en=1 and ofl_err=0.
